// File: rtl/data_ram_if.sv
// Request/response bus of data_ram: one access at a time, byte/halfword/word sizes.
interface data_ram_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [1:0]  size;
   logic [31:0] rd_data;
   logic        rd_vld;
   logic        busy;
   logic        err;

   modport master (
      output rd_en, wr_en, addr, wr_data, size,
      input  rd_data, rd_vld, busy, err
   );

   modport slave (
      input  rd_en, wr_en, addr, wr_data, size,
      output rd_data, rd_vld, busy, err
   );
endinterface

// File: rtl/data_ram.sv
// Word RAM with byte/halfword/word access and WAIT_CYC wait states per access.
// Optional misalignment checking enabled by defining DATA_RAM_ALIGN_CHK_EN.
module data_ram #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WAIT_CYC   = 0
) (
   input  logic       clk,
   input  logic       rst,
   data_ram_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, state_nxt;
   logic [3:0] wcnt, wcnt_nxt;
   logic       accept, done;

   logic [DEPTH_LOG2-1:0] l_idx;
   logic [1:0]            l_lo;
   logic [31:0]           l_data;
   logic [1:0]            l_size;
   logic                  l_wr, l_rd;

   logic [DEPTH_LOG2-1:0] c_idx;
   logic [1:0]            c_lo;
   logic [31:0]           c_data;
   logic [1:0]            c_size;
   logic                  c_wr, c_rd;
   logic [3:0]            c_be;
   logic [31:0]           c_wd;
   logic                  c_mis, wr_ok;

   logic [31:0] mem [2**DEPTH_LOG2];
   logic [31:0] rd_data_q;
   logic        rd_vld_q, err_q;

   assign accept = (bus.rd_en | bus.wr_en) && (state != WAIT);

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      done      = 1'b0;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (WAIT_CYC == 0) begin
                  state_nxt = RESP;
                  done      = 1'b1;
               end else begin
                  state_nxt = WAIT;
                  wcnt_nxt  = '0;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (wcnt == 4'(WAIT_CYC - 1)) begin
               state_nxt = RESP;
               done      = 1'b1;
            end else begin
               wcnt_nxt = wcnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Without wait states the access completes on its accept edge, straight from the bus.
   always_comb begin
      c_idx  = (WAIT_CYC == 0) ? bus.addr[DEPTH_LOG2+1:2] : l_idx;
      c_lo   = (WAIT_CYC == 0) ? bus.addr[1:0]            : l_lo;
      c_data = (WAIT_CYC == 0) ? bus.wr_data              : l_data;
      c_size = (WAIT_CYC == 0) ? bus.size                 : l_size;
      c_wr   = (WAIT_CYC == 0) ? bus.wr_en                : l_wr;
      c_rd   = (WAIT_CYC == 0) ? (bus.rd_en & ~bus.wr_en) : l_rd;
   end

   always_comb begin
      c_be = 4'b1111;
      c_wd = c_data;
      case (c_size)
         2'd0: begin
            c_be = 4'b0001 << c_lo;
            c_wd = {4{c_data[7:0]}};
         end
         2'd1: begin
            c_be = c_lo[1] ? 4'b1100 : 4'b0011;
            c_wd = {2{c_data[15:0]}};
         end
         default: begin
            c_be = 4'b1111;
            c_wd = c_data;
         end
      endcase
   end

`ifdef DATA_RAM_ALIGN_CHK_EN
   assign c_mis = ((c_size == 2'd1) && c_lo[0]) || (c_size[1] && (c_lo != 2'b00));
`else
   assign c_mis = 1'b0;
`endif
   assign wr_ok = done & c_wr & ~c_mis;

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wd[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= '0;
         l_idx     <= '0;
         l_lo      <= '0;
         l_data    <= '0;
         l_size    <= '0;
         l_wr      <= 1'b0;
         l_rd      <= 1'b0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (accept) begin
            l_idx  <= bus.addr[DEPTH_LOG2+1:2];
            l_lo   <= bus.addr[1:0];
            l_data <= bus.wr_data;
            l_size <= bus.size;
            l_wr   <= bus.wr_en;
            l_rd   <= bus.rd_en & ~bus.wr_en;
         end
         rd_vld_q <= done & c_rd;
         err_q    <= done & c_mis;
         if (done & c_rd) rd_data_q <= c_mis ? '0 : mem[c_idx];
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.rd_vld  = rd_vld_q;
   assign bus.err     = err_q;
   assign bus.busy    = (state == WAIT);

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-array depth = 2^DEPTH_LOG2 x 32 bit.
REQ-002 Parameter WAIT_CYC, default 0, range 0..15, wait states inserted per access.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rd_en  input  1  read request.
REQ-006 wr_en  input  1  write request.
REQ-007 addr  input  32  byte address.
REQ-008 wr_data  input  32  write data, low-justified (byte in [7:0], halfword in [15:0]).
REQ-009 size  input  2  access size: 0 byte, 1 halfword, 2/3 word.
REQ-010 rd_data  output  32  full aligned word read, registered.
REQ-011 rd_vld  output  1  one-cycle pulse, rd_data valid.
REQ-012 busy  output  1  access in progress; new requests ignored.
REQ-013 err  output  1  one-cycle pulse, misaligned access (see Configuration).

Function
REQ-014 Request accepted in cycle T when (rd_en|wr_en)=1 and busy=0; addr, wr_data, size and kind are latched at the T edge.
REQ-015 rd_en and wr_en both high at accept: treated as write only; no rd_vld.
REQ-016 Word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing wrap).
REQ-017 FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept when WAIT_CYC>0, IDLE->RESP on accept when WAIT_CYC=0; WAIT->RESP after WAIT_CYC cycles in WAIT; RESP->IDLE, or RESP->WAIT/RESP on a back-to-back accept.
REQ-018 busy = 1 exactly while in WAIT; with WAIT_CYC=0 busy never asserts.
REQ-019 Read: rd_vld=1 and rd_data valid in cycle T+WAIT_CYC+1, for exactly one cycle; rd_data holds its value until the next read completes.
REQ-020 Write commit on the edge entering RESP; byte lane = addr[1:0], halfword lane = addr[1]; wr_data shifted into the lane(s), other bytes unchanged.
REQ-021 Read of a word written by an earlier completed write returns the new data, including back-to-back accept in the RESP cycle.
REQ-022 Requests in RESP cycle with WAIT_CYC=0 accepted (one access per cycle throughput).
REQ-023 Memory array not reset; contents undefined until written.

Reset
REQ-024 rst=1 forces IDLE, rd_data=0, rd_vld=0, busy=0, err=0 immediately.
REQ-025 rst during WAIT aborts the access; a pending write is not committed, no rd_vld issued.
REQ-026 First request is accepted in the first cycle with rst=0.

Configuration
REQ-027 Macro DATA_RAM_ALIGN_CHK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is misaligned; err pulses in the completion cycle, the write is suppressed, a read returns rd_data=0 with rd_vld=1.
REQ-028 Macro undefined: err tied 0; misaligned accesses use addr rounded down to size alignment and complete normally.

Verification
REQ-029 WAIT_CYC=0: write 0xDEADBEEF word @0x10 at T, read @0x10 at T+1 -> rd_vld at T+2 with rd_data=0xDEADBEEF, busy never 1.
REQ-030 Byte write 0x000000AA @0x13 onto 0x11223344 -> read @0x10 returns 0xAA223344; halfword 0x5566 @0x12 -> 0x55663344.
REQ-031 WAIT_CYC=3: read accepted at T -> busy high T+1..T+3, rd_vld at T+4; rd_en held high during busy causes no extra access.
REQ-032 DEPTH_LOG2=8: write @0x400 then read @0x000 -> returns the written value (wrap).
REQ-033 WAIT_CYC=2: write accepted, rst pulsed at T+1 -> busy=0 immediately, later read of that word shows the old value.
REQ-034 DATA_RAM_ALIGN_CHK_EN: word write @0x11 -> err pulse, memory unchanged; without macro -> word written @0x10, err=0.
